cdr_trig_sequencer: RTL and testbench

CDR_TRIG_SEQUENCER -- requirements
Module: cdr_trig_sequencer

---
 rtl/cdr_trig_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cdr_trig_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdr_trig_sequencer.sv
// ============================================================================
// Module   : cdr_trig_sequencer
// Purpose  : Arm/lock/holdoff sequencer that turns qualified SERDES symbol
//            matches into a registered one-cycle trigger pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdr_trig_sequencer #(
    parameter int HOLDOFF_WIDTH = 16,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst,
    input  logic                     cfg_arm,
    input  logic                     cfg_disarm,
    input  logic [7:0]               cfg_mode,
    input  logic                     cfg_single,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_lock_timeout,
    input  logic                     lock_8b10b,
    input  logic                     lock_64b66b,
    input  logic                     match_valid,
    input  logic                     match_hit,
    output logic                     trig_out,
    output logic [2:0]               state,
    output logic [COUNT_WIDTH-1:0]   trig_count,
    output logic                     lock_lost,
    output logic                     lock_timeout,
    output logic                     mode_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_ARMED     = 3'd2,
        ST_HOLDOFF   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [HOLDOFF_WIDTH-1:0] c_HOLD_ZERO = '0;
    localparam logic [HOLDOFF_WIDTH-1:0] c_HOLD_ONE  = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]   c_CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    logic                     r_trig;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_lock_lost;
    logic                     r_lock_timeout;
    logic                     r_mode_err;
    logic [HOLDOFF_WIDTH-1:0] r_cnt;
    logic                     r_mode_64;
    logic                     r_single;
    logic [HOLDOFF_WIDTH-1:0] r_holdoff;
    logic [HOLDOFF_WIDTH-1:0] r_lock_to;

    logic                     w_mode_ok;
    logic                     w_lock;
    logic                     w_hit;
    logic [HOLDOFF_WIDTH-1:0] w_cnt_inc;
    logic [COUNT_WIDTH-1:0]   w_count_next;

    assign w_mode_ok    = (cfg_mode == 8'h00) || (cfg_mode == 8'h01) ||
                          (cfg_mode == 8'h80) || (cfg_mode == 8'h81);
    // Only bit 7 of the mode picks the aligner, so that is all we keep.
    assign w_lock       = r_mode_64 ? lock_64b66b : lock_8b10b;
    assign w_hit        = match_valid && match_hit;
    assign w_cnt_inc    = r_cnt + c_HOLD_ONE;
    assign w_count_next = (&r_count) ? r_count : (r_count + c_CNT_ONE);

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_state        <= ST_IDLE;
            r_trig         <= 1'b0;
            r_count        <= '0;
            r_lock_lost    <= 1'b0;
            r_lock_timeout <= 1'b0;
            r_mode_err     <= 1'b0;
            r_cnt          <= '0;
            r_mode_64      <= 1'b0;
            r_single       <= 1'b0;
            r_holdoff      <= '0;
            r_lock_to      <= '0;
        end else begin
            r_trig <= 1'b0;
            if (cfg_disarm) begin
                r_state <= ST_IDLE;
            end else if (cfg_arm) begin
                if (w_mode_ok) begin
                    r_mode_64      <= cfg_mode[7];
                    r_single       <= cfg_single;
                    r_holdoff      <= cfg_holdoff;
                    r_lock_to      <= cfg_lock_timeout;
                    r_count        <= '0;
                    r_lock_lost    <= 1'b0;
                    r_lock_timeout <= 1'b0;
                    r_mode_err     <= 1'b0;
                    r_cnt          <= '0;
                    r_state        <= ST_WAIT_LOCK;
                end else begin
                    r_mode_err <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_WAIT_LOCK: begin
                        if (w_lock) begin
                            r_state <= ST_ARMED;
                        end else if (r_lock_to != c_HOLD_ZERO) begin
                            if (w_cnt_inc == r_lock_to) begin
                                r_lock_timeout <= 1'b1;
                                r_state        <= ST_IDLE;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    ST_ARMED: begin
                        // Lock loss outranks a coincident hit.
                        if (!w_lock) begin
                            r_lock_lost <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ST_WAIT_LOCK;
                        end else if (w_hit) begin
                            r_trig  <= 1'b1;
                            r_count <= w_count_next;
                            if (r_single) begin
                                r_state <= ST_DONE;
                            end else if (r_holdoff == c_HOLD_ZERO) begin
                                r_state <= ST_ARMED;
                            end else begin
                                r_cnt   <= r_holdoff;
                                r_state <= ST_HOLDOFF;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (!w_lock) begin
                            r_lock_lost <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ST_WAIT_LOCK;
                        end else if (r_cnt <= c_HOLD_ONE) begin
                            r_cnt   <= '0;
                            r_state <= ST_ARMED;
                        end else begin
                            r_cnt <= r_cnt - c_HOLD_ONE;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign trig_out     = r_trig;
    assign state        = r_state;
    assign trig_count   = r_count;
    assign lock_lost    = r_lock_lost;
    assign lock_timeout = r_lock_timeout;
    assign mode_err     = r_mode_err;

endmodule

`default_nettype wire

// File: tb/tb_cdr_trig_sequencer.sv
// ============================================================================
// Module   : tb_cdr_trig_sequencer
// Purpose  : Directed scoreboard bench for cdr_trig_sequencer (4-bit count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdr_trig_sequencer;

    localparam int HW = 16;
    localparam int CW = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WL   = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_arm, cfg_disarm, cfg_single;
    logic [7:0]    cfg_mode;
    logic [HW-1:0] cfg_holdoff, cfg_lock_timeout;
    logic          lock_8b10b, lock_64b66b, match_valid, match_hit;
    logic          trig_out, lock_lost, lock_timeout, mode_err;
    logic [2:0]    state;
    logic [CW-1:0] trig_count;

    always #5 clk = ~clk;

    cdr_trig_sequencer #(.HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)) dut (
        .rx_clk(clk), .rx_rst(rst),
        .cfg_arm(cfg_arm), .cfg_disarm(cfg_disarm), .cfg_mode(cfg_mode),
        .cfg_single(cfg_single), .cfg_holdoff(cfg_holdoff),
        .cfg_lock_timeout(cfg_lock_timeout),
        .lock_8b10b(lock_8b10b), .lock_64b66b(lock_64b66b),
        .match_valid(match_valid), .match_hit(match_hit),
        .trig_out(trig_out), .state(state), .trig_count(trig_count),
        .lock_lost(lock_lost), .lock_timeout(lock_timeout), .mode_err(mode_err)
    );

    typedef struct {
        int            cyc;
        string         name;
        logic [2:0]    st;
        logic          trig;
        logic [CW-1:0] cnt;
        logic          ll;
        logic          lt;
        logic          me;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation is tagged with the cycle it belongs to.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (e.cyc == cyc && state === e.st && trig_out === e.trig &&
                trig_count === e.cnt && lock_lost === e.ll &&
                lock_timeout === e.lt && mode_err === e.me) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0d: got st=%0d trig=%0b cnt=%0d ll=%0b lt=%0b me=%0b, want st=%0d trig=%0b cnt=%0d ll=%0b lt=%0b me=%0b",
                         e.name, cyc, state, trig_out, trig_count, lock_lost,
                         lock_timeout, mode_err, e.st, e.trig, e.cnt, e.ll, e.lt, e.me);
            end
        end
    end

    // Push what the outputs must show after the next edge, then take that edge.
    task automatic step(input string nm, input logic [2:0] st, input logic tr,
                        input int cnt, input logic ll, input logic lt, input logic me);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.st   = st;
        e.trig = tr;
        e.cnt  = CW'(cnt);
        e.ll   = ll;
        e.lt   = lt;
        e.me   = me;
        q.push_back(e);
        @(posedge clk);
        #1;
        cfg_arm    = 1'b0;
        cfg_disarm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_arm = 1'b1; cfg_disarm = 1'b0; cfg_mode = 8'h00;
        cfg_single = 1'b0; cfg_holdoff = '0; cfg_lock_timeout = '0;
        lock_8b10b = 1'b1; lock_64b66b = 1'b1; match_valid = 1'b1; match_hit = 1'b1;
        @(posedge clk);
        #1;
        cfg_arm = 1'b1;
        step("reset_overrides_arm", S_IDLE, 0, 0, 0, 0, 0);
        rst = 1'b0; match_valid = 1'b0; match_hit = 1'b0;
        step("idle_after_reset", S_IDLE, 0, 0, 0, 0, 0);

        // Single-shot 64B/66B: only the 64B/66B lock matters.
        cfg_mode = 8'h80; cfg_single = 1'b1; lock_64b66b = 1'b1; lock_8b10b = 1'b0;
        cfg_arm = 1'b1;
        step("ss_arm", S_WL, 0, 0, 0, 0, 0);
        step("ss_lock", S_ARM, 0, 0, 0, 0, 0);
        step("ss_armed_wait", S_ARM, 0, 0, 0, 0, 0);
        match_valid = 1'b0; match_hit = 1'b1;
        step("ss_hit_not_valid", S_ARM, 0, 0, 0, 0, 0);
        match_valid = 1'b1;
        step("ss_trigger", S_DONE, 1, 1, 0, 0, 0);
        step("ss_done_no_trig", S_DONE, 0, 1, 0, 0, 0);
        step("ss_done_hold", S_DONE, 0, 1, 0, 0, 0);

        // Auto-rearm 8B/10B, holdoff 3, hit held high; later cfg edits must not matter.
        cfg_mode = 8'h00; cfg_single = 1'b0; cfg_holdoff = 16'd3;
        lock_8b10b = 1'b1; lock_64b66b = 1'b0; cfg_arm = 1'b1;
        step("ho_arm_clears", S_WL, 0, 0, 0, 0, 0);
        cfg_holdoff = 16'd0; cfg_single = 1'b1; cfg_mode = 8'h80;
        step("ho_lock", S_ARM, 0, 0, 0, 0, 0);
        for (int p = 1; p <= 4; p++) begin
            step("ho_pulse", S_HOLD, 1, p, 0, 0, 0);
            step("ho_wait1", S_HOLD, 0, p, 0, 0, 0);
            step("ho_wait2", S_HOLD, 0, p, 0, 0, 0);
            step("ho_rearm", S_ARM, 0, p, 0, 0, 0);
        end

        // Lock drop coincident with a hit, then lock drop in holdoff.
        lock_8b10b = 1'b0;
        step("ll_hit_suppressed", S_WL, 0, 4, 1, 0, 0);
        lock_8b10b = 1'b1; match_hit = 1'b0;
        step("ll_relock", S_ARM, 0, 4, 1, 0, 0);
        match_hit = 1'b1;
        step("ll_pulse", S_HOLD, 1, 5, 1, 0, 0);
        lock_8b10b = 1'b0;
        step("ll_in_holdoff", S_WL, 0, 5, 1, 0, 0);
        for (int i = 0; i < 15; i++) step("ll_wait_forever", S_WL, 0, 5, 1, 0, 0);

        // Lock timeout of 10 with the wrong aligner locked.
        cfg_mode = 8'h01; cfg_lock_timeout = 16'd10; lock_64b66b = 1'b1; cfg_arm = 1'b1;
        step("to_arm", S_WL, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("to_waiting", S_WL, 0, 0, 0, 0, 0);
        step("to_expired", S_IDLE, 0, 0, 0, 1, 0);
        step("to_idle_hold", S_IDLE, 0, 0, 0, 1, 0);

        // Mode errors and disarm priority.
        cfg_mode = 8'h42; cfg_arm = 1'b1;
        step("me_bad_mode", S_IDLE, 0, 0, 0, 1, 1);
        cfg_mode = 8'h81; cfg_arm = 1'b1; cfg_disarm = 1'b1;
        step("me_arm_disarm", S_IDLE, 0, 0, 0, 1, 1);
        cfg_arm = 1'b1; cfg_lock_timeout = 16'd0;
        step("me_good_arm", S_WL, 0, 0, 0, 0, 0);
        step("me_lock64", S_ARM, 0, 0, 0, 0, 0);
        cfg_mode = 8'h02; cfg_arm = 1'b1;
        step("me_bad_while_armed", S_IDLE, 0, 0, 0, 0, 1);
        cfg_mode = 8'h00; cfg_single = 1'b0; cfg_holdoff = 16'd0; lock_8b10b = 1'b1;
        cfg_arm = 1'b1;
        step("hz_arm", S_WL, 0, 0, 0, 0, 0);
        step("hz_lock", S_ARM, 0, 0, 0, 0, 0);
        cfg_disarm = 1'b1;
        step("dis_beats_hit", S_IDLE, 0, 0, 0, 0, 0);

        // Holdoff 0: back-to-back pulses, count saturating at 15.
        cfg_arm = 1'b1;
        step("sat_arm", S_WL, 0, 0, 0, 0, 0);
        step("sat_lock", S_ARM, 0, 0, 0, 0, 0);
        for (int p = 1; p <= 17; p++) step("sat_pulse", S_ARM, 1, (p > 15) ? 15 : p, 0, 0, 0);
        match_hit = 1'b0;
        step("sat_stop", S_ARM, 0, 15, 0, 0, 0);

        // Reset during a pulse and holdoff.
        cfg_holdoff = 16'd5; cfg_arm = 1'b1; match_hit = 1'b1;
        step("rh_arm", S_WL, 0, 0, 0, 0, 0);
        step("rh_lock", S_ARM, 0, 0, 0, 0, 0);
        step("rh_pulse", S_HOLD, 1, 1, 0, 0, 0);
        rst = 1'b1;
        step("rh_reset", S_IDLE, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("rh_no_residual", S_IDLE, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
